// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per cycle, MSB first.
// The quotient is also shown in decimal on active-low 7-segment digits.
module seq_divider #(
   parameter int N             = 4,
   parameter int DISPLAY_WIDTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [N-1:0]               m,
   input  logic [N-1:0]               q,
   output logic                       busy,
   output logic                       done,
   output logic [N-1:0]               quotient,
   output logic [N-1:0]               remainder,
   output logic                       divByZero,
   output logic [7*DISPLAY_WIDTH-1:0] displaySeg
);

   localparam int CW    = $clog2(N + 1);
   localparam int BCD_D = (N + 2) / 3;
   localparam int NDIG  = (BCD_D > DISPLAY_WIDTH) ? BCD_D : DISPLAY_WIDTH;

   function automatic longint unsigned pow10(input int n);
      longint unsigned p;
      p = 1;
      for (int i = 0; i < n; i++) p = p * 10;
      return p;
   endfunction

   localparam longint unsigned LIMIT = pow10(DISPLAY_WIDTH) - 1;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [N:0]    r_rem;
   logic [N-1:0]  r_dvd;
   logic [N-1:0]  r_dvs;
   logic [CW-1:0] r_cnt;
   logic          r_zero;
   logic          r_done;
   logic [N-1:0]  r_quo;
   logic [N-1:0]  r_remo;
   logic          r_dbz;

   logic          w_busy;
   logic [N:0]    w_shift;
   logic [N:0]    w_diff;
   logic          w_ge;

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      w_busy = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) w_next = (q == '0) ? DONE : CALC;
         end
         CALC: begin
            w_busy = 1'b1;
            if (r_cnt == CW'(1)) w_next = DONE;
         end
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Partial remainder is one bit wider so the shifted value never wraps.
   assign w_shift = (r_rem << 1) | {{N{1'b0}}, r_dvd[N-1]};
   assign w_ge    = (w_shift >= {1'b0, r_dvs});
   assign w_diff  = w_shift - {1'b0, r_dvs};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rem  <= '0;
         r_dvd  <= '0;
         r_dvs  <= '0;
         r_cnt  <= '0;
         r_zero <= 1'b0;
         r_done <= 1'b0;
         r_quo  <= '0;
         r_remo <= '0;
         r_dbz  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_dvd  <= m;
                  r_dvs  <= q;
                  r_rem  <= '0;
                  r_cnt  <= CW'(N);
                  r_zero <= (q == '0);
               end
            end
            CALC: begin
               r_rem <= w_ge ? w_diff : w_shift;
               r_dvd <= {r_dvd[N-2:0], w_ge};
               r_cnt <= r_cnt - CW'(1);
            end
            DONE: begin
               r_done <= 1'b1;
               if (r_zero) begin
                  r_quo  <= '1;
                  r_remo <= r_dvd;
                  r_dbz  <= 1'b1;
               end else begin
                  r_quo  <= r_dvd;
                  r_remo <= r_rem[N-1:0];
                  r_dbz  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy      = w_busy;
   assign done      = r_done;
   assign quotient  = r_quo;
   assign remainder = r_remo;
   assign divByZero = r_dbz;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   logic [4*NDIG-1:0]          w_bcd;
   logic                       w_over;
   logic [7*DISPLAY_WIDTH-1:0] w_disp;

   // Double-dabble: add 3 to any digit >= 5 before each shift.
   always_comb begin
      w_bcd = '0;
      for (int i = N - 1; i >= 0; i--) begin
         for (int d = 0; d < NDIG; d++) begin
            if (w_bcd[4*d +: 4] >= 4'd5)
               w_bcd[4*d +: 4] = w_bcd[4*d +: 4] + 4'd3;
         end
         w_bcd = {w_bcd[4*NDIG-2:0], r_quo[i]};
      end
   end

   assign w_over = (64'(r_quo) > LIMIT);

   always_comb begin
      w_disp = '0;
      for (int d = 0; d < DISPLAY_WIDTH; d++) begin
         w_disp[7*d +: 7] = w_over ? 7'b0111111 : seg7(w_bcd[4*d +: 4]);
      end
   end

   assign displaySeg = w_disp;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: N=4 and N=8 instances, directed
// vectors plus a full 4-bit operand sweep.
module tb_seq_divider;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  m = '0;
   logic [3:0]  q = '0;
   logic        busy4, done4, dbz4;
   logic [3:0]  quo4, rem4;
   logic [13:0] seg4;

   logic        start8 = 1'b0;
   logic [7:0]  m8 = '0;
   logic [7:0]  q8 = '0;
   logic        busy8, done8, dbz8;
   logic [7:0]  quo8, rem8;
   logic [13:0] seg8;

   always #5 clk = ~clk;

   seq_divider #(.N(4), .DISPLAY_WIDTH(2)) u4 (
      .clk(clk), .rst(rst), .start(start), .m(m), .q(q),
      .busy(busy4), .done(done4), .quotient(quo4),
      .remainder(rem4), .divByZero(dbz4), .displaySeg(seg4)
   );

   seq_divider #(.N(8), .DISPLAY_WIDTH(2)) u8 (
      .clk(clk), .rst(rst), .start(start8), .m(m8), .q(q8),
      .busy(busy8), .done(done8), .quotient(quo8),
      .remainder(rem8), .divByZero(dbz8), .displaySeg(seg8)
   );

   typedef struct {
      logic [7:0]  quo;
      logic [7:0]  rem;
      logic        dbz;
      logic [13:0] seg;
   } exp_t;

   exp_t sb4[$];
   exp_t sb8[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [6:0] tab(input int d);
      case (d)
         0:       return 7'b1000000;
         1:       return 7'b1111001;
         2:       return 7'b0100100;
         3:       return 7'b0110000;
         4:       return 7'b0011001;
         5:       return 7'b0010010;
         6:       return 7'b0000010;
         7:       return 7'b1111000;
         8:       return 7'b0000000;
         9:       return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [13:0] seg2(input int v);
      if (v > 99) return {2{7'b0111111}};
      return {tab(v / 10), tab(v % 10)};
   endfunction

   function automatic exp_t mk4(input int mm, input int qq);
      exp_t e;
      if (qq == 0) begin
         e.quo = 8'd15;
         e.rem = 8'(mm);
         e.dbz = 1'b1;
         e.seg = seg2(15);
      end else begin
         e.quo = 8'(mm / qq);
         e.rem = 8'(mm % qq);
         e.dbz = 1'b0;
         e.seg = seg2(mm / qq);
      end
      return e;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (done4) begin
         if (sb4.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL done4_unexpected: got 1 expected 0");
         end else begin
            e = sb4.pop_front();
            chk("quotient4", quo4, e.quo);
            chk("remainder4", rem4, e.rem);
            chk("divByZero4", dbz4, e.dbz);
            chk("displaySeg4", seg4, e.seg);
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (done8) begin
         if (sb8.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL done8_unexpected: got 1 expected 0");
         end else begin
            e = sb8.pop_front();
            chk("quotient8", quo8, e.quo);
            chk("remainder8", rem8, e.rem);
            chk("divByZero8", dbz8, e.dbz);
            chk("displaySeg8", seg8, e.seg);
         end
      end
   end

   // poke keeps start high and scrambles operands while the division runs.
   task automatic run4(input logic [3:0] mm, input logic [3:0] qq,
                       input exp_t e, input bit poke,
                       output int lat, output int nbusy);
      sb4.push_back(e);
      @(negedge clk);
      m     = mm;
      q     = qq;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      nbusy = int'(busy4);
      lat   = -1;
      if (poke) begin
         m = ~mm;
         q = 4'd1;
      end else begin
         start = 1'b0;
      end
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (done4) begin
            lat = k;
            break;
         end
         nbusy += int'(busy4);
      end
      start = 1'b0;
   endtask

   task automatic run8(input logic [7:0] mm, input logic [7:0] qq,
                       input exp_t e, output int lat);
      sb8.push_back(e);
      @(negedge clk);
      m8     = mm;
      q8     = qq;
      start8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start8 = 1'b0;
      lat    = -1;
      for (int k = 1; k <= 30; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (done8) begin
            lat = k;
            break;
         end
      end
   endtask

   initial begin
      int lat, nb, cnt;
      exp_t e;

      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_busy", busy4, 0);
      chk("rst_done", done4, 0);
      chk("rst_quotient", quo4, 0);
      chk("rst_remainder", rem4, 0);
      chk("rst_divByZero", dbz4, 0);
      chk("rst_display", seg4, {7'b1000000, 7'b1000000});
      chk("rst_display8", seg8, {7'b1000000, 7'b1000000});

      e = '{8'd3, 8'd1, 1'b0, {7'b1000000, 7'b0110000}};
      run4(4'd13, 4'd4, e, 1'b0, lat, nb);
      chk("lat_13_4", lat, 5);
      chk("busy_13_4", nb, 4);
      chk("disp_13_4", seg4, {7'b1000000, 7'b0110000});

      e = '{8'd15, 8'd9, 1'b1, {7'b1111001, 7'b0010010}};
      run4(4'd9, 4'd0, e, 1'b0, lat, nb);
      chk("lat_9_0", lat, 1);
      chk("busy_9_0", nb, 0);

      e = '{8'd4, 8'd0, 1'b0, {7'b1000000, 7'b0011001}};
      run4(4'd8, 4'd2, e, 1'b0, lat, nb);
      chk("lat_8_2", lat, 5);
      chk("dbz_clear_8_2", dbz4, 0);

      @(negedge clk);
      m     = 4'd15;
      q     = 4'd1;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", busy4, 0);
      chk("abort_done", done4, 0);
      chk("abort_quotient", quo4, 0);
      chk("abort_remainder", rem4, 0);
      chk("abort_divByZero", dbz4, 0);
      chk("abort_display", seg4, {7'b1000000, 7'b1000000});
      cnt = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         cnt += int'(done4) + int'(busy4);
      end
      chk("abort_idle", cnt, 0);

      e = '{8'd2, 8'd1, 1'b0, {7'b1000000, 7'b0100100}};
      run4(4'd7, 4'd3, e, 1'b1, lat, nb);
      chk("lat_7_3_poke", lat, 5);
      cnt = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         cnt += int'(done4);
      end
      chk("single_done_7_3", cnt, 0);

      for (int mi = 0; mi < 16; mi++) begin
         for (int qi = 0; qi < 16; qi++) begin
            run4(4'(mi), 4'(qi), mk4(mi, qi), 1'b0, lat, nb);
            chk("sweep_lat", lat, (qi == 0) ? 1 : 5);
            chk("sweep_busy", nb, (qi == 0) ? 0 : 4);
         end
      end

      e = '{8'd200, 8'd0, 1'b0, {2{7'b0111111}}};
      run8(8'd200, 8'd1, e, lat);
      chk("lat8_200_1", lat, 9);
      chk("dash8_200_1", seg8, {7'b0111111, 7'b0111111});

      e = '{8'd99, 8'd0, 1'b0, {7'b0010000, 7'b0010000}};
      run8(8'd198, 8'd2, e, lat);
      chk("lat8_198_2", lat, 9);

      repeat (3) @(negedge clk);
      chk("sb4_empty", sb4.size(), 0);
      chk("sb8_empty", sb8.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter N, default 4: width of the dividend, divisor, quotient and remainder.
REQ-002 SHALL have parameter DISPLAY_WIDTH, default 2: number of 7-segment digits driven for the quotient.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: request a division with the current operands.
REQ-006 SHALL have port m, input, N bits: unsigned dividend.
REQ-007 SHALL have port q, input, N bits: unsigned divisor.
REQ-008 SHALL have port busy, output, 1 bit: high while the iteration is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse marking a valid result.
REQ-010 SHALL have port quotient, output, N bits: registered quotient.
REQ-011 SHALL have port remainder, output, N bits: registered remainder.
REQ-012 SHALL have port divByZero, output, 1 bit: set when the last result had q==0.
REQ-013 SHALL have port displaySeg, output, 7*DISPLAY_WIDTH bits: decimal quotient in 7-segment form.

Function
REQ-014 SHALL implement the states IDLE, CALC and DONE.
REQ-015 In IDLE with start=1 and q!=0, the block SHALL latch m and q, clear the partial remainder, load the iteration counter with N, and go to CALC.
REQ-016 In IDLE with start=1 and q==0, the block SHALL go directly to DONE with quotient all ones, remainder=m and divByZero=1.
REQ-017 In CALC, each cycle SHALL perform one restoring-division step, MSB first: shift {rem,dividend} left by 1; if rem>=divisor, subtract and set the quotient bit to 1, else set it to 0.
REQ-018 The partial remainder SHALL be N+1 bits wide internally so that the compare never overflows.
REQ-019 CALC SHALL last exactly N cycles, after which the state goes to DONE.
REQ-020 On entering DONE, quotient and remainder SHALL update and done=1 for exactly one cycle; the state then returns to IDLE.
REQ-021 Latency: for q!=0, with start sampled at edge E0, done SHALL be high in the cycle after edge E0+N+1; for q==0, done SHALL be high in the cycle after E0+1.
REQ-022 busy SHALL be 1 only in CALC.
REQ-023 start SHALL be ignored in CALC and DONE, with no queuing.
REQ-024 Changes on m and q after acceptance SHALL NOT affect the result in progress.
REQ-025 quotient, remainder and divByZero SHALL hold their values until the next DONE.
REQ-026 divByZero SHALL clear on the next DONE for which q!=0.
REQ-027 displaySeg SHALL show quotient in unsigned decimal using combinational binary-to-BCD conversion, with leading zeros shown.
REQ-028 displaySeg digit 0 (least significant) SHALL occupy bits [6:0].
REQ-029 Within each digit, bit 0 SHALL be segment a and bit 6 SHALL be segment g; segments are active-low.
REQ-030 If quotient exceeds 10^DISPLAY_WIDTH-1, every digit SHALL show a dash (7'b0111111).
REQ-031 If start=1 on the same edge that DONE returns to IDLE, the start SHALL be ignored; a new start is accepted only when sampled in IDLE.

Reset
REQ-032 While rst=1 at a clock edge, the state SHALL become IDLE and busy, done, quotient, remainder and divByZero SHALL all become 0.
REQ-033 Following reset, displaySeg SHALL show '0' on every digit (7'b1000000 per digit).
REQ-034 Reset asserted during CALC SHALL abort the division, with no done pulse and no output update.
REQ-035 rst SHALL take priority over start.

Verification
REQ-036 With N=4, m=13, q=4 and a start pulse, the bench SHALL check busy=1 for 4 cycles, then done=1 for 1 cycle, quotient=3, remainder=1 and displaySeg={7'b1000000,7'b0110000}.
REQ-037 With m=9 and q=0, the bench SHALL check done in the cycle after E0+1, busy never high, quotient=15, remainder=9, divByZero=1 and display "15"; a following m=8, q=2 SHALL give quotient=4 and divByZero=0.
REQ-038 The bench SHALL assert rst for 1 cycle at the 2nd CALC cycle of m=15, q=1 and check that the state returns to IDLE, no done pulse occurs and outputs=0.
REQ-039 The bench SHALL pulse start during CALC and DONE of m=7, q=3 and check that the result is still quotient=2, remainder=1 with exactly one done pulse.
REQ-040 The bench SHALL sweep all 256 (m,q) pairs back-to-back and compare against m/q and m%q, with q==0 cases checked against REQ-016.
REQ-041 With N=8, DISPLAY_WIDTH=2, m=200 and q=1, the bench SHALL check quotient=200 and that both digits show a dash.
